// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stall_ctrl
// Brief   : Pipeline stall controller and multi-cycle EX sequencer.
//           Optional stall statistics counter under PIPE_STALL_STAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
   parameter int STALL_W = 6,
   parameter int CNT_W   = 4
`ifdef PIPE_STALL_STAT_EN
   ,
   parameter int STAT_W  = 32
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_id,
   input  logic               ex_mc_req,
   input  logic [CNT_W-1:0]   ex_mc_len,
   output logic               ex_mc_busy_o,
   output logic [CNT_W-1:0]   ex_mc_cnt_o,
   output logic               ex_mc_last_o,
   output logic [STALL_W-1:0] stall
`ifdef PIPE_STALL_STAT_EN
   ,
   output logic [STAT_W-1:0]  stall_cycles_o
`endif
);

   localparam logic [0:0]         c_IDLE     = 1'b0;
   localparam logic [0:0]         c_RUN      = 1'b1;
   localparam logic [STALL_W-1:0] c_STALL_EX = STALL_W'(6'b001111);
   localparam logic [STALL_W-1:0] c_STALL_ID = STALL_W'(6'b000111);
   localparam logic [CNT_W-1:0]   c_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0]   c_TWO      = CNT_W'(2);

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_len;

   logic             w_live;
   logic             w_run;
   logic [CNT_W-1:0] w_len_m1;
   logic             w_start;
   logic             w_at_last;
   logic             w_ex_stall;

   // Outputs are forced quiet while reset is held, even those fed by inputs.
   always_comb begin
      w_live     = ~rst;
      w_run      = (r_state == c_RUN);
      w_len_m1   = r_len - c_ONE;
      w_start    = ~w_run & ex_mc_req & (ex_mc_len >= c_TWO);
      w_at_last  = w_run & (r_cnt == w_len_m1);
      w_ex_stall = w_live & (w_start | (w_run & ex_mc_req & (r_cnt < w_len_m1)));
   end

   always_comb begin
      ex_mc_busy_o = w_live & w_run;
      ex_mc_cnt_o  = (w_live & w_run) ? r_cnt : '0;
      if (!w_live)
         ex_mc_last_o = 1'b0;
      else if (w_run)
         ex_mc_last_o = ex_mc_req & w_at_last;
      else
         ex_mc_last_o = ex_mc_req & (ex_mc_len < c_TWO);

      if (w_ex_stall)
         stall = c_STALL_EX;
      else if (w_live & stallreq_id)
         stall = c_STALL_ID;
      else
         stall = '0;
   end

   // A dropped request in RUN is an abort: return to IDLE without retiring.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_cnt   <= '0;
         r_len   <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_start) begin
                  r_state <= c_RUN;
                  r_cnt   <= c_ONE;
                  r_len   <= ex_mc_len;
               end
            end
            c_RUN: begin
               if (!ex_mc_req || w_at_last) begin
                  r_state <= c_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt + c_ONE;
               end
            end
            default: begin
               r_state <= c_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_STALL_STAT_EN
   logic [STAT_W-1:0] r_stall_cycles;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cycles <= '0;
      else if (stall[0] && (r_stall_cycles != '1))
         r_stall_cycles <= r_stall_cycles + STAT_W'(1);
   end

   assign stall_cycles_o = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline stall controller and multi-cycle EX sequencer for the 5-stage MIPS core. It combines the ID-stage stall request with a counter-based state machine. That machine holds the pipeline while the EX stage runs multi-cycle ops (MADD/MADDU/MSUB/MSUBU, iterative MULT/MULTU). It drives the per-stage stall vector to pc_reg, if_id, id_ex, ex_mem and mem_wb, and gives EX its iteration index.

Parameters:
STALL_W, 6, stall vector width; bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
CNT_W, 4, width of iteration counter and length field
STAT_W, 32, width of optional stall statistics counter

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
stallreq_id  in  1  ID stage requests stall
ex_mc_req  in  1  EX holds a multi-cycle op
ex_mc_len  in  CNT_W  total EX cycles the op needs; sampled at start
ex_mc_busy_o  out  1  sequencer in RUN state
ex_mc_cnt_o  out  CNT_W  current iteration index for EX datapath
ex_mc_last_o  out  1  current cycle is the final EX iteration
stall  out  STALL_W  per-stage stall vector

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, len_q=0.
  - All outputs 0, including stall=6'b000000.
- State IDLE, start condition ex_mc_req=1 and ex_mc_len>=2:
  - ex_mc_cnt_o=0, ex_mc_last_o=0, EX stall asserted this cycle (combinational).
  - Next edge: RUN, cnt<=1, len_q<=ex_mc_len.
- State IDLE, ex_mc_req=1 and ex_mc_len in {0,1}: single-cycle op, no stall, ex_mc_last_o=1, ex_mc_cnt_o=0, stays IDLE.
- State IDLE, ex_mc_req=0: ex_mc_last_o=0, ex_mc_cnt_o=0.
- State RUN:
  - ex_mc_busy_o=1, ex_mc_cnt_o=cnt.
  - cnt<len_q-1: EX stall asserted; cnt<=cnt+1 each edge.
  - cnt==len_q-1: ex_mc_last_o=1, EX stall released so the op retires; next edge -> IDLE, cnt<=0.
- ex_mc_len changes while in RUN: ignored; len_q governs.
- ex_mc_req drops in RUN (flush/abort): EX stall released the same cycle, ex_mc_last_o=0; next edge -> IDLE, cnt<=0.
- Stall vector, combinational, priority order:
  - EX stall (IDLE start condition, or RUN with cnt<len_q-1): 6'b001111.
  - Else stallreq_id=1: 6'b000111. EX receives a bubble; this also applies on the ex_mc_last_o cycle.
  - Else 6'b000000.
- Back-to-back multi-cycle ops: a new start is accepted in the first IDLE cycle after retirement. No dead cycle.
- Counter wrap: impossible, since cnt<=len_q-1 <= 2^CNT_W-2.
- Reset asserted mid-RUN: immediate IDLE, stall=0.

Optional Feature:
Macro PIPE_STALL_STAT_EN.
- Defined:
  - Adds output stall_cycles_o (STAT_W), a counter that increments every cycle stall[0]=1.
  - Saturates at all-ones.
  - Async reset to 0.
- Undefined: port and counter absent. All other behaviour identical.

Test Plan:
1. Reset: rst=1 pulse mid-RUN (len=5, cnt=2) -> next sample state IDLE, stall=000000, cnt_o=0, busy=0.
2. MADD len=2: req=1 in cycle0 -> stall=001111, cnt_o=0. Cycle1: cnt_o=1, last=1, stall=000000. Cycle2: busy=0.
3. MULT len=5 held: stall=001111 for cycles 0..3; last=1 and stall=0 in cycle4; cnt_o sequence 0,1,2,3,4. Changing len to 9 at cycle2 has no effect.
4. ID stall only (req=0, stallreq_id=1) -> stall=000111. With req=1, len=3 in IDLE plus stallreq_id=1 -> 001111. On the last cycle plus stallreq_id=1 -> 000111.
5. Abort: len=6, req drops at cnt=3 -> stall=000000 the same cycle, last=0; next cycle IDLE, cnt_o=0.
6. PIPE_STALL_STAT_EN: run scenarios 2 and 3 back-to-back (the second starting the cycle after the first retires) -> stall_cycles_o=5. Force counter to all-ones, stall 1 cycle -> stays all-ones.
